// File: rtl/ap_ctrl_driver_pkg.sv
// Shared types and defaults for the ap_ctrl_chain traffic driver.
package ap_ctrl_driver_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned MAX_OUT_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_chain handshake bundle between the driver (master) and the kernel under test (slave).
interface ap_ctrl_driver_if;

    logic dut_ap_start;
    logic dut_ap_continue;
    logic dut_ap_ready;
    logic dut_ap_done;

    modport master (
        output dut_ap_start,
        output dut_ap_continue,
        input  dut_ap_ready,
        input  dut_ap_done
    );

    modport slave (
        input  dut_ap_start,
        input  dut_ap_continue,
        output dut_ap_ready,
        output dut_ap_done
    );

endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// Start-timestamp FIFO; each entry carries a sticky flag raised once its age reaches all-ones.
module ap_ctrl_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] now,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head_ts,
    output logic             head_sat
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] ts_mem [DEPTH];
    logic [DEPTH-1:0] sat;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            sat    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
        end else begin
            // Age would wrap next cycle: remember that the latency is now saturated.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ts_mem[i] == now + WIDTH'(1)) sat[i] <= 1'b1;
            end
            if (push) begin
                ts_mem[wr_ptr] <= now;
                sat[wr_ptr]    <= 1'b0;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    assign head_ts  = ts_mem[rd_ptr];
    assign head_sat = sat[rd_ptr];

endmodule

// File: rtl/ap_ctrl_driver.sv
// Drives a run of ap_ctrl_chain transactions and tracks counts; statistics are built
// only when AP_CTRL_DRIVER_STATS_EN is defined (outputs tied to 0 otherwise).
module ap_ctrl_driver
    import ap_ctrl_driver_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_num_txn,
    input  logic [7:0]            cfg_cont_gap,
    ap_ctrl_driver_if.master      dut,
    output logic                  run_busy,
    output logic                  run_done,
    output logic [CNT_W-1:0]      started_cnt,
    output logic [CNT_W-1:0]      done_cnt,
    output logic [CNT_W-1:0]      last_latency,
    output logic [CNT_W-1:0]      max_latency,
    output logic [CNT_W-1:0]      last_interval,
    output logic                  err_unexp_done
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    state_t           state;
    logic [CNT_W-1:0] num_txn;
    logic [7:0]       cont_gap;
    logic [7:0]       gap_cnt;
    logic [OW-1:0]    outstanding;
    logic             start_r;
    logic             cont_r;

    logic             start_acc;
    logic             done_acc;
    logic             done_valid;
    logic             load;
    logic [CNT_W-1:0] started_nx;
    logic [CNT_W-1:0] done_nx;
    logic [OW-1:0]    out_nx;

    always_comb begin
        start_acc  = start_r & dut.dut_ap_ready;
        done_acc   = dut.dut_ap_done & cont_r;
        done_valid = done_acc & (outstanding != '0);
        load       = (state == S_IDLE) & cfg_start;
        started_nx = started_cnt + CNT_W'(start_acc);
        done_nx    = done_cnt + CNT_W'(done_valid);
        out_nx     = outstanding + OW'(start_acc) - OW'(done_valid);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= S_IDLE;
            num_txn        <= '0;
            cont_gap       <= '0;
            gap_cnt        <= '0;
            outstanding    <= '0;
            start_r        <= 1'b0;
            cont_r         <= 1'b1;
            started_cnt    <= '0;
            done_cnt       <= '0;
            run_done       <= 1'b0;
            err_unexp_done <= 1'b0;
        end else begin
            run_done <= 1'b0;
            if (done_acc && outstanding == '0) err_unexp_done <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (load) begin
                        num_txn     <= cfg_num_txn;
                        cont_gap    <= cfg_cont_gap;
                        started_cnt <= '0;
                        done_cnt    <= '0;
                        outstanding <= '0;
                        gap_cnt     <= '0;
                        cont_r      <= 1'b1;
                        start_r     <= (cfg_num_txn != '0);
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    started_cnt <= started_nx;
                    done_cnt    <= done_nx;
                    outstanding <= out_nx;
                    if (done_nx == num_txn) begin
                        // The final done ends the run; continue stays high through FIN.
                        state    <= S_FIN;
                        run_done <= 1'b1;
                        start_r  <= 1'b0;
                        cont_r   <= 1'b1;
                        gap_cnt  <= '0;
                    end else begin
                        start_r <= (started_nx < num_txn) && (out_nx < OW'(MAX_OUT));
                        if (done_valid && cont_gap != '0) begin
                            cont_r  <= 1'b0;
                            gap_cnt <= cont_gap;
                        end else if (!cont_r) begin
                            if (gap_cnt == 8'd1) cont_r <= 1'b1;
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign run_busy            = (state == S_RUN);
    assign dut.dut_ap_start    = start_r;
    assign dut.dut_ap_continue = cont_r;

`ifdef AP_CTRL_DRIVER_STATS_EN
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ivl_cnt;
    logic [CNT_W-1:0] head_ts;
    logic [CNT_W-1:0] lat_now;
    logic [CNT_W-1:0] last_lat_r;
    logic [CNT_W-1:0] max_lat_r;
    logic [CNT_W-1:0] last_ivl_r;
    logic             head_sat;
    logic             have_prev;

    ap_ctrl_ts_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (CNT_W)
    ) u_ts_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .now      (cyc_cnt),
        .push     (start_acc),
        .pop      (done_valid),
        .head_ts  (head_ts),
        .head_sat (head_sat)
    );

    always_comb lat_now = head_sat ? '1 : cyc_cnt - head_ts;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cyc_cnt    <= '0;
            ivl_cnt    <= '0;
            last_lat_r <= '0;
            max_lat_r  <= '0;
            last_ivl_r <= '0;
            have_prev  <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (load) begin
                ivl_cnt    <= '0;
                last_lat_r <= '0;
                max_lat_r  <= '0;
                last_ivl_r <= '0;
                have_prev  <= 1'b0;
            end else begin
                // Saturating distance since the previous start acceptance.
                if (ivl_cnt != '1) ivl_cnt <= ivl_cnt + CNT_W'(1);
                if (start_acc) begin
                    if (have_prev) last_ivl_r <= ivl_cnt;
                    have_prev <= 1'b1;
                    ivl_cnt   <= CNT_W'(1);
                end
                if (done_valid) begin
                    last_lat_r <= lat_now;
                    if (lat_now > max_lat_r) max_lat_r <= lat_now;
                end
            end
        end
    end

    assign last_latency  = last_lat_r;
    assign max_latency   = max_lat_r;
    assign last_interval = last_ivl_r;
`else
    assign last_latency  = '0;
    assign max_latency   = '0;
    assign last_interval = '0;
`endif

endmodule

// File: doc/ap_ctrl_driver.md
AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the counters and statistics.
REQ-002 SHALL have parameter MAX_OUT, default 4 (power of two, at most 16), giving the maximum number of outstanding transactions.
REQ-003 SHALL have port ap_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start, input, 1 bit: single-cycle request to begin a run.
REQ-006 SHALL have port cfg_num_txn, input, CNT_W bits: transactions in the run, sampled on an accepted cfg_start.
REQ-007 SHALL have port cfg_cont_gap, input, 8 bits: ap_continue low-hold cycles after each accepted done, sampled on an accepted cfg_start.
REQ-008 SHALL have port dut_ap_start, output, 1 bit: ap_ctrl_chain start to the DUT.
REQ-009 SHALL have port dut_ap_continue, output, 1 bit: ap_ctrl_chain continue to the DUT.
REQ-010 SHALL have port dut_ap_ready, input, 1 bit: DUT ready.
REQ-011 SHALL have port dut_ap_done, input, 1 bit: DUT done.
REQ-012 SHALL have port run_busy, output, 1 bit: high in state RUN.
REQ-013 SHALL have port run_done, output, 1 bit: one-cycle pulse at end of run.
REQ-014 SHALL have ports started_cnt and done_cnt, outputs, CNT_W bits each: accepted starts and dones in the current run.
REQ-015 SHALL have ports last_latency, max_latency and last_interval, outputs, CNT_W bits each: statistics outputs.
REQ-016 SHALL have port err_unexp_done, output, 1 bit: sticky error flag for a done with nothing outstanding.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and FIN.
REQ-018 IDLE with cfg_start SHALL load the configuration, clear the counters and statistics, and enter RUN on the next edge.
REQ-019 cfg_start outside IDLE SHALL be ignored.
REQ-020 A start SHALL be accepted on a cycle where dut_ap_start and dut_ap_ready are both 1; started_cnt increments on the next edge.
REQ-021 dut_ap_start SHALL be registered and high in RUN while started_cnt < num_txn and outstanding < MAX_OUT, counting the acceptance in the current cycle.
REQ-022 A done SHALL be accepted on a cycle where dut_ap_done and dut_ap_continue are both 1; done_cnt increments.
REQ-023 outstanding SHALL equal started minus done; a simultaneous start and done leave it unchanged.
REQ-024 dut_ap_continue SHALL be 1 except for exactly cfg_cont_gap cycles immediately after each accepted done.
REQ-025 With cfg_cont_gap = 0, dut_ap_continue SHALL stay permanently 1.
REQ-026 In IDLE and FIN, dut_ap_continue SHALL be 1.
REQ-027 RUN SHALL move to FIN on the edge where done_cnt reaches num_txn.
REQ-028 FIN SHALL pulse run_done for one cycle, then return to IDLE.
REQ-029 cfg_num_txn = 0 SHALL go RUN to FIN immediately, with dut_ap_start never asserted.
REQ-030 A done accepted with outstanding = 0 SHALL set err_unexp_done, be ignored by the counters, and stay set until reset.
REQ-031 Latency SHALL be the cycle count from start acceptance to the matching done acceptance, matched in FIFO order.
REQ-032 last_interval SHALL be the cycle count between consecutive start acceptances.
REQ-033 All statistics SHALL saturate at all-ones and never wrap.
REQ-034 started_cnt and done_cnt SHALL wrap modulo 2^CNT_W.

Reset
REQ-035 Asserting ap_rst_n low at any time, including mid-run, SHALL clear every register and output to 0, except dut_ap_continue which resets to 1.
REQ-036 After reset the FSM SHALL be in IDLE.
REQ-037 Outstanding transactions at reset SHALL be discarded.

Configuration
REQ-038 Macro AP_CTRL_DRIVER_STATS_EN defined SHALL include the free-running cycle counter, the timestamp FIFO, and last_latency, max_latency and last_interval.
REQ-039 AP_CTRL_DRIVER_STATS_EN undefined SHALL tie those three outputs to 0, omit the FIFO, and leave all handshake behaviour cycle-identical.

Structure
REQ-040 Package ap_ctrl_driver_pkg SHALL hold the FSM state enum, the CNT_W default and the MAX_OUT default.
REQ-041 Sub-module ap_ctrl_ts_fifo, MAX_OUT deep and CNT_W wide, SHALL store start timestamps.
REQ-042 The FIFO SHALL push on start acceptance and pop on done acceptance, supporting simultaneous push and pop when full.

Verification
REQ-043 Reset with cfg_num_txn=3, gap=0, ready tied 1, done 5 cycles after each start -> 3 starts, done_cnt=3, last_latency=5, run_done pulses once, no error.
REQ-044 MAX_OUT=4, num_txn=10, done withheld -> dut_ap_start drops after 4 accepted starts and resumes the cycle after the first done.
REQ-045 cfg_cont_gap=3 -> dut_ap_continue low exactly 3 cycles after each done; a done held during that window is accepted when continue returns to 1.
REQ-046 cfg_num_txn=0 -> run_done pulses 2 cycles after cfg_start and dut_ap_start stays 0.
REQ-047 dut_ap_done pulsed in IDLE -> err_unexp_done=1, counters unchanged; then ap_rst_n low mid-run -> all outputs 0, dut_ap_continue=1, FSM in IDLE.
REQ-048 Latency counter forced near saturation with CNT_W=8 and a 300-cycle latency -> last_latency=255 and max_latency=255.
